// File: rtl/legv8_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : legv8_pkg
//  Brief    : Shared constants for the LEGv8 program-counter slice: opcode
//             match patterns, default datapath width and sequential step.
//  Revision : 1.0 - initial release
// ============================================================================
package legv8_pkg;

  // Default datapath width and sequential PC increment (bytes)
  localparam int LEGV8_WIDTH   = 64;
  localparam int LEGV8_PC_STEP = 4;

  // Opcode match patterns, compared against the top bits of opcode[10:0]
  localparam logic [5:0] OPC_B    = 6'b000101;    // opcode[10:5]
  localparam logic [7:0] OPC_CBZ  = 8'b10110100;  // opcode[10:3]
  localparam logic [7:0] OPC_CBNZ = 8'b10110101;  // opcode[10:3]

  // Branch class of an instruction, as far as the PC is concerned
  typedef enum logic [1:0] {
    BR_NONE   = 2'd0,
    BR_UNCOND = 2'd1,
    BR_CBZ    = 2'd2,
    BR_CBNZ   = 2'd3
  } br_kind_e;

  // Classify an 11-bit opcode field into a branch kind
  function automatic br_kind_e classify_opcode(input logic [10:0] opcode);
    br_kind_e kind;
    kind = BR_NONE;
    if (opcode[10:5] == OPC_B) begin
      kind = BR_UNCOND;
    end else if (opcode[10:3] == OPC_CBZ) begin
      kind = BR_CBZ;
    end else if (opcode[10:3] == OPC_CBNZ) begin
      kind = BR_CBNZ;
    end
    return kind;
  endfunction

endpackage : legv8_pkg
`default_nettype wire

// File: rtl/pc_branch_decode.sv
`default_nettype none
// ============================================================================
//  Module   : pc_branch_decode
//  Brief    : Combinational branch decision. Asserts take_branch for B, for
//             CBZ with a zero ALU result and, when PC_COUNTER_CBNZ_EN is
//             defined, for CBNZ with a non-zero ALU result.
//  Config   : PC_COUNTER_CBNZ_EN (optional CBNZ support)
//  Revision : 1.0 - initial release
// ============================================================================
module pc_branch_decode
  import legv8_pkg::*;
(
  input  logic [10:0] opcode,
  input  logic        zero,
  output logic        take_branch
);

  br_kind_e kind;

  // Decide whether the current instruction redirects the PC
  always_comb begin
    kind        = classify_opcode(opcode);
    take_branch = 1'b0;
    case (kind)
      BR_UNCOND: take_branch = 1'b1;
      BR_CBZ:    take_branch = zero;
`ifdef PC_COUNTER_CBNZ_EN
      BR_CBNZ:   take_branch = ~zero;
`else
      // Without CBNZ support the opcode is an ordinary sequential instruction
      BR_CBNZ:   take_branch = 1'b0;
`endif
      default:   take_branch = 1'b0;
    endcase
  end

endmodule : pc_branch_decode
`default_nettype wire

// File: rtl/pc_counter.sv
`default_nettype none
// ============================================================================
//  Module   : pc_counter
//  Brief    : LEGv8 program counter register. Each non-reset edge loads
//             pc + PC_STEP or, when the decoder requests a branch,
//             pc + extended_shifted. Arithmetic wraps modulo 2^WIDTH.
//  Config   : PC_COUNTER_CBNZ_EN (optional CBNZ support, see decoder)
//  Revision : 1.0 - initial release
// ============================================================================
module pc_counter
  import legv8_pkg::*;
#(
  parameter int               WIDTH    = LEGV8_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               PC_STEP  = LEGV8_PC_STEP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] alu_output,
  input  logic [WIDTH-1:0] extended_shifted,
  input  logic [10:0]      opcode,
  output logic [WIDTH-1:0] pc
);

  localparam logic [WIDTH-1:0] C_PC_STEP = WIDTH'(PC_STEP);

  logic             zero;
  logic             take_branch;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] pc_q;

  assign zero = (alu_output == '0);

  pc_branch_decode u_branch_decode (
    .opcode      (opcode),
    .zero        (zero),
    .take_branch (take_branch)
  );

  // Select the next address; extended_shifted is already a byte offset
  always_comb begin
    pc_d = pc_q + C_PC_STEP;
    if (take_branch) begin
      pc_d = pc_q + extended_shifted;
    end
  end

  // PC register with synchronous reset taking priority over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule : pc_counter
`default_nettype wire

// File: tb/tb_pc_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_counter
//  Brief    : Self-checking bench for pc_counter: directed vector table
//             followed by randomized cycles against a behavioural model.
//  Config   : PC_COUNTER_CBNZ_EN changes expected CBNZ behaviour
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_counter;

  typedef struct {
    logic        rst;
    logic [10:0] opc;
    logic [63:0] alu;
    logic [63:0] ext;
    logic [63:0] exp_pc;
  } vec_t;

  localparam int NVEC  = 19;
  localparam int NRAND = 400;

  logic        clk;
  logic        rst;
  logic [63:0] alu_output;
  logic [63:0] extended_shifted;
  logic [10:0] opcode;
  logic [63:0] pc;

  int n_checks;
  int n_fail;

  vec_t        vecs [NVEC];
  logic [63:0] model_pc;

  pc_counter dut (
    .clk              (clk),
    .rst              (rst),
    .alu_output       (alu_output),
    .extended_shifted (extended_shifted),
    .opcode           (opcode),
    .pc               (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference next-PC rule expressed with plain integer arithmetic
  function automatic logic [63:0] model_next(input logic [63:0] cur,
                                             input logic        r,
                                             input logic [10:0] op,
                                             input logic [63:0] alu,
                                             input logic [63:0] ext);
    int unsigned top6;
    int unsigned top8;
    top6 = int'(op) / 32;
    top8 = int'(op) / 8;
    if (r) return 64'd0;
    if (top6 == 5) return cur + ext;
    if (top8 == 180 && alu == 64'd0) return cur + ext;
`ifdef PC_COUNTER_CBNZ_EN
    if (top8 == 181 && alu != 64'd0) return cur + ext;
`endif
    return cur + 64'd4;
  endfunction

  task automatic apply(input logic r, input logic [10:0] op,
                       input logic [63:0] alu, input logic [63:0] ext);
    rst              = r;
    opcode           = op;
    alu_output       = alu;
    extended_shifted = ext;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] exp);
    n_checks++;
    if (pc !== exp) begin
      n_fail++;
      $display("FAIL %s: pc=%h expected=%h", name, pc, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; opcode = '0; alu_output = '0; extended_shifted = '0;

    vecs[0]  = '{1'b1, 11'h000, 64'h0,                 64'h0,      64'h0};
    vecs[1]  = '{1'b1, 11'h0A0, 64'h0,                 64'h40,     64'h0};
    vecs[2]  = '{1'b0, 11'h000, 64'h123,               64'h999,    64'h4};
    vecs[3]  = '{1'b0, 11'h000, 64'h0,                 64'h999,    64'h8};
    vecs[4]  = '{1'b0, 11'h000, 64'hDEAD,              64'h0,      64'hC};
    vecs[5]  = '{1'b0, 11'h0A0, 64'h1,                 64'h5730,   64'h573C};
    vecs[6]  = '{1'b0, 11'h0A0, 64'h0,                 64'h5730,   64'hAE6C};
    vecs[7]  = '{1'b0, 11'h5A0, 64'h58807FAF92A25FE0,  64'h32,     64'hAE70};
    vecs[8]  = '{1'b0, 11'h5A0, 64'h58807FAF92A25FE0,  64'h32,     64'hAE74};
    vecs[9]  = '{1'b0, 11'h5A0, 64'h0,                 64'h32,     64'hAEA6};
    vecs[10] = '{1'b0, 11'h5A0, 64'h0,                 64'h32,     64'hAED8};
    vecs[11] = '{1'b0, 11'h5A0, 64'h0,                 64'h32,     64'hAF0A};
    vecs[12] = '{1'b1, 11'h0A0, 64'h0,                 64'h32,     64'h0};
    vecs[13] = '{1'b0, 11'h0A0, 64'h0,  64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFC};
    vecs[14] = '{1'b0, 11'h0BF, 64'h77,                64'h8,      64'h4};
    vecs[15] = '{1'b0, 11'h5A7, 64'h0,                 64'h10,     64'h14};
    vecs[16] = '{1'b0, 11'h5A4, 64'h1,                 64'h10,     64'h18};
`ifdef PC_COUNTER_CBNZ_EN
    vecs[17] = '{1'b0, 11'h5A8, 64'h7,                 64'h20,     64'h38};
    vecs[18] = '{1'b0, 11'h5A8, 64'h0,                 64'h20,     64'h3C};
`else
    vecs[17] = '{1'b0, 11'h5A8, 64'h7,                 64'h20,     64'h1C};
    vecs[18] = '{1'b0, 11'h5A8, 64'h0,                 64'h20,     64'h20};
`endif

    for (int i = 0; i < NVEC; i++) begin
      apply(vecs[i].rst, vecs[i].opc, vecs[i].alu, vecs[i].ext);
      check($sformatf("vec%0d", i), vecs[i].exp_pc);
    end

    // Multi-cycle: reset held with a branch opcode present, then release
    apply(1'b1, 11'h0A0, 64'h0, 64'h100);
    check("hold_rst_a", 64'h0);
    apply(1'b1, 11'h5A0, 64'h0, 64'h100);
    check("hold_rst_b", 64'h0);
    apply(1'b0, 11'h5A0, 64'h0, 64'h100);
    check("release_cbz", 64'h100);

    // Randomized cycles against the behavioural model
    model_pc = 64'h100;
    for (int i = 0; i < NRAND; i++) begin
      logic        r;
      logic [10:0] op;
      logic [63:0] alu;
      logic [63:0] ext;
      r = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 4))
        0: op = 11'h0A0 | 11'($urandom_range(0, 31));
        1: op = 11'h5A0 | 11'($urandom_range(0, 7));
        2: op = 11'h5A8 | 11'($urandom_range(0, 7));
        default: op = 11'($urandom);
      endcase
      alu = ($urandom_range(0, 1) == 0) ? 64'd0 : {$urandom, $urandom};
      ext = {$urandom, $urandom};
      model_pc = model_next(model_pc, r, op, alu, ext);
      apply(r, op, alu, ext);
      check($sformatf("rand%0d", i), model_pc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule : tb_pc_counter
`default_nettype wire
